// File: rtl/sprite_line_buffer_dual.sv
// sprite_line_buffer_dual: double-banked sprite line buffer, clear-on-read scanout, sweep clears
module sprite_line_buffer_dual #(
  parameter int PIX_W          = 8,
  parameter int PEN_W          = 4,
  parameter int X_W            = 10,
  parameter int DEPTH          = 512,
  parameter int LANES          = 2,
  parameter int PRIORITY_FIRST = 0
) (
  input  logic                   CLK_32M,
  input  logic                   RESET_N,
  input  logic                   BANK_SEL,
  input  logic                   WR_EN,
  input  logic [X_W-1:0]         WR_X,
  input  logic                   WR_FLIP,
  input  logic [LANES*PIX_W-1:0] WR_DATA,
  input  logic [LANES-1:0]       WR_VALID,
  input  logic                   FLUSH,
  input  logic                   CE_PIX,
  input  logic [X_W-1:0]         RD_X,
  output logic [PIX_W-1:0]       DOUT,
  output logic                   DOUT_VALID,
  output logic                   BUSY
);
  localparam int N  = DEPTH / LANES;
  localparam int AW = N > 1 ? $clog2(N) : 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int DW = $clog2(DEPTH);
  typedef enum logic [1:0] {CLR_ALL, RUN, CLR_WB} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic wb_q, wb_d;
  logic [PIX_W-1:0] dout_q;
  logic valid_q;
  logic [PIX_W-1:0] mem_q [2][LANES][N];
  logic [DEPTH-1:0] occ_q [2];
  logic sweep_all, sweep_wb;
  logic [X_W-1:0] tgt [LANES];
  logic [LW-1:0] wl [LANES];
  logic [AW-1:0] wa [LANES];
  logic [DW-1:0] wi [LANES];
  logic [LANES-1:0] we;
  logic rb, rd_ok, rd_clr;
  logic [LW-1:0] rl;
  logic [AW-1:0] ra;
  logic [DW-1:0] ri;
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      state_q <= CLR_ALL;
      cnt_q   <= '0;
      wb_q    <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      valid_q <= CE_PIX;
      if (CE_PIX) dout_q <= rd_clr ? mem_q[rb][rl][ra] : '0;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    if (state_q == RUN) begin
      if (FLUSH) begin
        state_d = CLR_WB;
        wb_d    = BANK_SEL;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(N - 1)) state_d = RUN;
    end
  end
  always_comb begin
    BUSY      = state_q != RUN;
    sweep_all = state_q == CLR_ALL;
    sweep_wb  = state_q == CLR_WB;
  end
  // Lane targets wrap modulo 2^X_W; anything past DEPTH is dropped
  always_comb begin
    we = '0;
    for (int i = 0; i < LANES; i++) begin
      tgt[i] = WR_FLIP ? WR_X - X_W'(i) : WR_X + X_W'(i);
      wl[i]  = LW'(32'(tgt[i]) % LANES);
      wa[i]  = AW'(32'(tgt[i]) / LANES);
      wi[i]  = DW'(tgt[i]);
      we[i]  = state_q == RUN && WR_EN && WR_VALID[i] && |WR_DATA[i*PIX_W +: PEN_W] &&
               32'(tgt[i]) < DEPTH && (PRIORITY_FIRST == 0 || !occ_q[BANK_SEL][wi[i]]);
    end
  end
  always_comb begin
    rb     = ~BANK_SEL;
    rd_ok  = 32'(RD_X) < DEPTH;
    rd_clr = CE_PIX && !sweep_all && rd_ok;
    rl     = LW'(32'(RD_X) % LANES);
    ra     = AW'(32'(RD_X) / LANES);
    ri     = DW'(RD_X);
  end
  always_ff @(posedge CLK_32M) begin
    if (RESET_N) begin
      if (rd_clr) begin
        mem_q[rb][rl][ra] <= '0;
        occ_q[rb][ri]     <= 1'b0;
      end
      for (int i = 0; i < LANES; i++)
        if (we[i]) begin
          mem_q[BANK_SEL][wl[i]][wa[i]] <= WR_DATA[i*PIX_W +: PIX_W];
          occ_q[BANK_SEL][wi[i]]        <= 1'b1;
        end
      for (int b = 0; b < 2; b++)
        for (int l = 0; l < LANES; l++)
          if (sweep_all || (sweep_wb && wb_q == 1'(b))) begin
            mem_q[b][l][cnt_q]                   <= '0;
            occ_q[b][DW'(32'(cnt_q) * LANES + l)] <= 1'b0;
          end
    end
  end
  assign DOUT       = dout_q;
  assign DOUT_VALID = valid_q;
endmodule

// File: tb/tb_sprite_line_buffer_dual.sv
// tb_sprite_line_buffer_dual: random + directed bench, both priority modes against an array model
module tb_sprite_line_buffer_dual;
  localparam int DEPTH = 512;
  localparam int N = 256;
  logic CLK_32M = 1'b0;
  logic RESET_N = 1'b0, BANK_SEL = 1'b0, WR_EN = 1'b0, WR_FLIP = 1'b0, FLUSH = 1'b0, CE_PIX = 1'b0;
  logic [9:0] WR_X = '0, RD_X = '0;
  logic [15:0] WR_DATA = '0;
  logic [1:0] WR_VALID = '0;
  logic [7:0] dout [2];
  logic dv [2], busy [2];
  int n_checks = 0, n_errors = 0;
  logic [7:0] mm [2][2][DEPTH];
  bit mo [2][2][DEPTH];
  logic [7:0] m_dout [2];
  logic m_valid;
  int left;
  sprite_line_buffer_dual #(.PRIORITY_FIRST(0)) u_last (
    .CLK_32M(CLK_32M), .RESET_N(RESET_N), .BANK_SEL(BANK_SEL), .WR_EN(WR_EN), .WR_X(WR_X),
    .WR_FLIP(WR_FLIP), .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .FLUSH(FLUSH), .CE_PIX(CE_PIX),
    .RD_X(RD_X), .DOUT(dout[0]), .DOUT_VALID(dv[0]), .BUSY(busy[0]));
  sprite_line_buffer_dual #(.PRIORITY_FIRST(1)) u_first (
    .CLK_32M(CLK_32M), .RESET_N(RESET_N), .BANK_SEL(BANK_SEL), .WR_EN(WR_EN), .WR_X(WR_X),
    .WR_FLIP(WR_FLIP), .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .FLUSH(FLUSH), .CE_PIX(CE_PIX),
    .RD_X(RD_X), .DOUT(dout[1]), .DOUT_VALID(dv[1]), .BUSY(busy[1]));
  always #5 CLK_32M = ~CLK_32M;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_bank(input int b);
    for (int d = 0; d < 2; d++)
      for (int x = 0; x < DEPTH; x++) begin
        mm[d][b][x] = '0;
        mo[d][b][x] = 1'b0;
      end
  endtask
  task automatic model_step();
    int t;
    logic [7:0] px;
    if (!RESET_N) begin
      clear_bank(0);
      clear_bank(1);
      m_dout[0] = '0;
      m_dout[1] = '0;
      m_valid = 1'b0;
      left = N;
      return;
    end
    m_valid = CE_PIX;
    for (int d = 0; d < 2; d++)
      if (CE_PIX) begin
        if (RD_X < DEPTH) begin
          m_dout[d] = mm[d][!BANK_SEL][RD_X];
          mm[d][!BANK_SEL][RD_X] = '0;
          mo[d][!BANK_SEL][RD_X] = 1'b0;
        end else m_dout[d] = '0;
      end
    if (left > 0) left--;
    else begin
      if (WR_EN)
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < 2; i++) begin
            t = (int'(WR_X) + (WR_FLIP ? -i : i) + 1024) % 1024;
            px = WR_DATA[i*8 +: 8];
            if (WR_VALID[i] && px[3:0] != 0 && t < DEPTH && (d == 0 || !mo[d][BANK_SEL][t])) begin
              mm[d][BANK_SEL][t] = px;
              mo[d][BANK_SEL][t] = 1'b1;
            end
          end
      if (FLUSH) begin
        clear_bank(int'(BANK_SEL));
        left = N;
      end
    end
  endtask
  task automatic tick();
    @(posedge CLK_32M);
    model_step();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dout%0d", d), dout[d], m_dout[d]);
      check($sformatf("valid%0d", d), dv[d], m_valid);
      check($sformatf("busy%0d", d), busy[d], left > 0);
    end
  endtask
  task automatic rd(input int x);
    CE_PIX = 1'b1;
    RD_X = 10'(x);
    tick();
    CE_PIX = 1'b0;
  endtask
  task automatic wr(input int x, input logic flip, input logic [15:0] data, input logic [1:0] valid);
    WR_EN = 1'b1;
    WR_X = 10'(x);
    WR_FLIP = flip;
    WR_DATA = data;
    WR_VALID = valid;
    tick();
    WR_EN = 1'b0;
  endtask
  task automatic rand_beat();
    WR_EN = 1'($urandom_range(0, 1));
    WR_X = $urandom_range(0, 1) ? 10'($urandom_range(0, 511)) : 10'($urandom_range(0, 1023));
    WR_FLIP = 1'($urandom_range(0, 1));
    WR_DATA = 16'($urandom);
    WR_VALID = 2'($urandom);
  endtask
  task automatic wait_busy(input string tag);
    int n = 1;
    while (busy[0] && n < 1000) begin
      tick();
      if (busy[0]) n++;
    end
    check(tag, n, N);
  endtask
  initial begin
    int n;
    tick();
    RESET_N = 1'b1;
    wait_busy("rst_busy_len");
    for (int b = 0; b < 2; b++) begin
      BANK_SEL = 1'(~b);
      for (int x = 0; x < DEPTH; x++) begin
        rd(x);
        check("rst_clear", {dout[1], dout[0]}, 0);
      end
    end
    BANK_SEL = 1'b0;
    wr(10, 1'b0, 16'h4235, 2'b11);
    BANK_SEL = 1'b1;
    rd(10); check("basic_10", dout[0], 8'h35);
    rd(11); check("basic_11", dout[0], 8'h42);
    rd(10); check("basic_clr", dout[0], 8'h00);
    wr(20, 1'b1, 16'h705A, 2'b11);
    BANK_SEL = 1'b0;
    rd(20); check("flip_20", dout[1], 8'h5A);
    rd(19); check("flip_19", dout[1], 8'h00);
    wr(4, 1'b0, 16'h0011, 2'b01);
    wr(4, 1'b0, 16'h0022, 2'b01);
    BANK_SEL = 1'b1;
    rd(4);
    check("prio_last", dout[0], 8'h22);
    check("prio_first", dout[1], 8'h11);
    BANK_SEL = 1'b0;
    wr(511, 1'b0, 16'h9291, 2'b11);
    BANK_SEL = 1'b1;
    rd(511); check("bound_511", dout[0], 8'h91);
    rd(600); check("bound_600", dout[0], 8'h00);
    check("bound_600_v", dv[0], 1'b1);
    rd(0); check("bound_wrap", dout[0], 8'h00);
    repeat (2000) begin
      rand_beat();
      CE_PIX = 1'($urandom_range(0, 1));
      RD_X = 10'($urandom_range(0, 600));
      if ($urandom_range(0, 15) == 0) BANK_SEL = ~BANK_SEL;
      tick();
    end
    CE_PIX = 1'b0;
    BANK_SEL = 1'b0;
    repeat (300) begin rand_beat(); tick(); end
    BANK_SEL = 1'b1;
    repeat (300) begin rand_beat(); tick(); end
    WR_EN = 1'b0;
    BANK_SEL = 1'b0;
    FLUSH = 1'b1;
    tick();
    n = 1;
    repeat (100) begin
      rand_beat();
      FLUSH = 1'($urandom_range(0, 1));
      CE_PIX = 1'b1;
      RD_X = 10'($urandom_range(0, 511));
      tick();
      if (busy[0]) n++;
    end
    BANK_SEL = 1'b1;
    CE_PIX = 1'b0;
    repeat (50) begin
      rand_beat();
      FLUSH = 1'($urandom_range(0, 1));
      tick();
      if (busy[0]) n++;
    end
    BANK_SEL = 1'b0;
    FLUSH = 1'b0;
    while (busy[0] && n < 1000) begin
      rand_beat();
      CE_PIX = 1'b1;
      RD_X = 10'($urandom_range(0, 511));
      tick();
      if (busy[0]) n++;
    end
    check("flush_busy_len", n, N);
    WR_EN = 1'b0;
    CE_PIX = 1'b0;
    BANK_SEL = 1'b1;
    for (int x = 0; x < DEPTH; x++) begin
      rd(x);
      check("flush_zero", {dout[1], dout[0]}, 0);
    end
    BANK_SEL = 1'b0;
    repeat (100) begin rand_beat(); tick(); end
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    wait_busy("rst2_busy_len");
    BANK_SEL = 1'b1;
    for (int x = 0; x < 32; x++) begin
      rd(x);
      check("rst2_clear", {dout[1], dout[0]}, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sprite_line_buffer_dual.md
Name: sprite_line_buffer_dual

Overview:
Parametrised double-banked sprite line buffer, the successor to the current two-pixel line buffer pair. While the sprite engine renders line N+1 into one bank, the scanout reads line N from the other, clearing each entry as it is read. Generalised to LANES pixels per write beat, optional X flip, and selectable first- or last-write-wins priority. Adds an explicit clear sweep after reset and on request. Sits between the sprite pixel shifter and the video mixer.

Parameters:
PIX_W, 8, pixel width: {color, pen}
PEN_W, 4, low pen bits; pen==0 is transparent and never written
X_W, 10, X coordinate width
DEPTH, 512, entries per bank; must be a multiple of LANES
LANES, 2, pixels per write beat; 1, 2 or 4
PRIORITY_FIRST, 0, 0 = later write overwrites; 1 = first opaque write to an entry wins

Ports:
CLK_32M  in  1  clock
RESET_N  in  1  synchronous active-low reset
BANK_SEL  in  1  write bank index; read bank = ~BANK_SEL
WR_EN  in  1  write beat strobe
WR_X  in  X_W  X of lane 0
WR_FLIP  in  1  0: lane i -> WR_X+i; 1: lane i -> WR_X-i
WR_DATA  in  LANES*PIX_W  lane i at bits [i*PIX_W +: PIX_W]
WR_VALID  in  LANES  per-lane enable
FLUSH  in  1  pulse: clear the current write bank
CE_PIX  in  1  scanout pixel enable
RD_X  in  X_W  scanout X
DOUT  out  PIX_W  read pixel
DOUT_VALID  out  1  one-cycle pulse, DOUT updated
BUSY  out  1  clear sweep in progress

Behaviour:
- Each bank is LANES interleaved memories indexed by X mod LANES, plus a DEPTH-bit occupancy vector. One beat touches each interleave at most once.
- FSM states: CLR_ALL, RUN, CLR_WB.
- Reset (RESET_N=0 at an edge): DOUT=0, DOUT_VALID=0, BUSY=1, sweep counter=0, state=CLR_ALL. Reset mid-sweep or mid-line restarts CLR_ALL.
- CLR_ALL: each cycle zeroes LANES consecutive entries and their occupancy in both banks. Takes DEPTH/LANES cycles, then RUN with BUSY=0 on the following cycle.
- RUN + FLUSH: latch BANK_SEL, go to CLR_WB with BUSY=1. Sweep only the latched bank for DEPTH/LANES cycles, then return to RUN.
- During a sweep:
  - BANK_SEL changes do not redirect the sweep.
  - FLUSH is ignored.
  - Writes are dropped.
  - Reads still operate in CLR_WB (the read bank is not swept) but return 0 in CLR_ALL.
- Write (RUN, WR_EN=1): for each lane i with WR_VALID[i]=1 and pen bits !=0, compute target = WR_X±i modulo 2^X_W.
  - Drop the lane if target >= DEPTH.
  - PRIORITY_FIRST=0: write unconditionally and set occupancy.
  - PRIORITY_FIRST=1: write only if occupancy is clear.
  - Committed at the clock edge; no backpressure.
- Read: on CE_PIX=1, the next edge sets DOUT <= read_bank[RD_X] and DOUT_VALID=1, and zeroes that entry and its occupancy on the same edge (read-before-clear).
  - RD_X >= DEPTH: DOUT=0 and nothing is cleared.
  - Without CE_PIX, DOUT holds and DOUT_VALID=0.
- Read and write always target different banks, so same-cycle read and write never collide.
- On a BANK_SEL toggle, the very next cycle uses the new banks. Prior writes are visible to reads from that cycle.
- Two lanes of one beat never map to the same entry. Wrap-around is modulo 2^X_W; with flip, WR_X=0 lane 1 -> 1023 -> dropped.

Test Plan:
1. Reset: hold RESET_N=0 for 1 cycle, release -> BUSY=1 for exactly 256 cycles (DEPTH=512, LANES=2); after that, reading every X of both banks returns 0.
2. Basic: BANK_SEL=0, write X=10 data {8'h35,8'h42} all valid; toggle BANK_SEL, CE_PIX at RD_X=10,11 -> DOUT=8'h35 then 8'h42. A second read of 10 -> 8'h00 (cleared).
3. Transparency and flip: write X=20, WR_FLIP=1, data {lane1=8'h70, lane0=8'h5A} -> entry 20=8'h5A, entry 19 untouched (pen 0) and reads 0.
4. Priority: PRIORITY_FIRST=1, write X=4 8'h11, then X=4 8'h22 -> reads 8'h11. With PRIORITY_FIRST=0 -> reads 8'h22.
5. Bounds: write X=511 lanes {8'h91,8'h92} -> entry 511=8'h91, lane 1 (512) dropped. RD_X=600 -> DOUT=0.
6. Flush: fill the write bank, pulse FLUSH, toggle BANK_SEL mid-sweep, issue writes during BUSY -> latched bank is all zero after 256 cycles, writes during BUSY are lost, and the other bank's reads still return its data.
